// File: rtl/cla_pkg.sv
// cla_pkg: shared widths, operand type and second-level carry lookahead.
package cla_pkg;
  localparam int CLA_WIDTH = 32;
  localparam int CLA_GRP = 4;
  localparam int CLA_NGRP = 8;
  typedef logic [CLA_WIDTH-1:0] cla_word_t;
  // Sum-of-products carry into group k: every term is a flat AND, so no group-to-group ripple.
  function automatic logic group_carry(input logic [CLA_NGRP-1:0] gg, gp, input logic ci, input int k);
    logic c, t;
    c = 1'b0;
    for (int j = 0; j < CLA_NGRP; j++) begin
      t = gg[j];
      for (int m = 0; m < CLA_NGRP; m++) t = (m > j && m < k) ? t & gp[m] : t;
      c = (j < k) ? c | t : c;
    end
    t = ci;
    for (int m = 0; m < CLA_NGRP; m++) t = (m < k) ? t & gp[m] : t;
    return c | t;
  endfunction
endpackage

// File: rtl/cla_32bit_if.sv
// cla_32bit_if: operand/result bundle; ovf exists only when CLA_32BIT_OVF_EN is defined.
interface cla_32bit_if;
  import cla_pkg::*;
  cla_word_t a, b, sum;
  logic cin, cout;
`ifdef CLA_32BIT_OVF_EN
  logic ovf;
  modport master(output a, b, cin, input sum, cout, ovf);
  modport slave(input a, b, cin, output sum, cout, ovf);
`else
  modport master(output a, b, cin, input sum, cout);
  modport slave(input a, b, cin, output sum, cout);
`endif
endinterface

// File: rtl/cla_4bit.sv
// cla_4bit: 4-bit lookahead group producing sum bits and group generate/propagate.
module cla_4bit
  import cla_pkg::*;
(
  input  logic [CLA_GRP-1:0] a,
  input  logic [CLA_GRP-1:0] b,
  input  logic               ci,
  output logic [CLA_GRP-1:0] s,
  output logic               G,
  output logic               P
);
  logic [CLA_GRP-1:0] gen, prop, c;
  assign gen = a & b;
  assign prop = a ^ b;
  assign c[0] = ci;
  assign c[1] = gen[0] | (prop[0] & ci);
  assign c[2] = gen[1] | (prop[1] & gen[0]) | (&prop[1:0] & ci);
  assign c[3] = gen[2] | (prop[2] & gen[1]) | (&prop[2:1] & gen[0]) | (&prop[2:0] & ci);
  assign s = prop ^ c;
  assign G = gen[3] | (prop[3] & gen[2]) | (&prop[3:2] & gen[1]) | (&prop[3:1] & gen[0]);
  assign P = &prop;
endmodule

// File: rtl/cla_32bit.sv
// cla_32bit: registered 32-bit two-level carry-lookahead adder.
// Define CLA_32BIT_OVF_EN to add the registered signed-overflow output.
module cla_32bit
  import cla_pkg::*;
(
  input logic          clk,
  input logic          rst_n,
  cla_32bit_if.slave   bus
);
  logic [CLA_NGRP-1:0] gg, gp;
  logic [CLA_NGRP:0]   gc;
  cla_word_t           sum_next;
  for (genvar i = 0; i < CLA_NGRP; i++) begin : g_grp
    cla_4bit u_grp (
      .a (bus.a[i*CLA_GRP +: CLA_GRP]),
      .b (bus.b[i*CLA_GRP +: CLA_GRP]),
      .ci(gc[i]),
      .s (sum_next[i*CLA_GRP +: CLA_GRP]),
      .G (gg[i]),
      .P (gp[i])
    );
  end
  for (genvar k = 0; k <= CLA_NGRP; k++) begin : g_carry
    assign gc[k] = group_carry(gg, gp, bus.cin, k);
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      bus.sum  <= '0;
      bus.cout <= 1'b0;
    end else begin
      bus.sum  <= sum_next;
      bus.cout <= gc[CLA_NGRP];
    end
`ifdef CLA_32BIT_OVF_EN
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) bus.ovf <= 1'b0;
    else bus.ovf <= (bus.a[31] == bus.b[31]) & (sum_next[31] != bus.a[31]);
`endif
endmodule

// File: tb/tb_cla_32bit.sv
// tb_cla_32bit: directed vector table, reset/hold corner cases and a random scoreboard.
module tb_cla_32bit;
  typedef struct {
    logic [31:0] a, b;
    logic        cin;
    logic [31:0] sum;
    logic        cout;
  } vec_t;

  logic clk = 1'b0, rst_n = 1'b1;
  int n_cmp = 0, n_bad = 0;
  cla_32bit_if bus();
  cla_32bit dut(.clk(clk), .rst_n(rst_n), .bus(bus));
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic drive(input logic [31:0] a, input logic [31:0] b, input logic cin);
    bus.a = a;
    bus.b = b;
    bus.cin = cin;
  endtask

`ifdef CLA_32BIT_OVF_EN
  function automatic logic exp_ovf(input logic [31:0] a, input logic [31:0] b, input logic [31:0] s);
    return (a[31] == b[31]) && (s[31] != a[31]);
  endfunction
`endif

  vec_t vt[10];
  logic [32:0] ref_sum;

  initial begin
    vt[0] = '{32'h00000001, 32'h0000FFFF, 1'b0, 32'h00010000, 1'b0};
    vt[1] = '{32'h0000A1B2, 32'h0000A112, 1'b0, 32'h000142C4, 1'b0};
    vt[2] = '{32'h0000F9A0, 32'h0000D7E8, 1'b1, 32'h0001D189, 1'b0};
    vt[3] = '{32'h00000FFF, 32'hF0010000, 1'b1, 32'hF0011000, 1'b0};
    vt[4] = '{32'hFFFFFFFF, 32'h00000001, 1'b0, 32'h00000000, 1'b1};
    vt[5] = '{32'hFFFFFFFF, 32'h00000000, 1'b1, 32'h00000000, 1'b1};
    vt[6] = '{32'hFFFFFFFF, 32'hFFFFFFFF, 1'b1, 32'hFFFFFFFF, 1'b1};
    vt[7] = '{32'h80000000, 32'h80000000, 1'b0, 32'h00000000, 1'b1};
    vt[8] = '{32'h7FFFFFFF, 32'h00000001, 1'b0, 32'h80000000, 1'b0};
    vt[9] = '{32'h12345678, 32'h87654321, 1'b1, 32'h9999999A, 1'b0};

    drive(32'h11111111, 32'h22222222, 1'b1);
    #1 rst_n = 1'b0;
    #1;
    check("reset_sum", 64'(bus.sum), 64'h0);
    check("reset_cout", 64'(bus.cout), 64'h0);
`ifdef CLA_32BIT_OVF_EN
    check("reset_ovf", 64'(bus.ovf), 64'h0);
`endif
    @(posedge clk); #1;
    check("reset_hold_sum", 64'(bus.sum), 64'h0);
    @(negedge clk) rst_n = 1'b1;
    #1 check("pre_capture_sum", 64'(bus.sum), 64'h0);

    foreach (vt[i]) begin
      drive(vt[i].a, vt[i].b, vt[i].cin);
      @(posedge clk); #1;
      check($sformatf("vec%0d_sum", i), 64'(bus.sum), 64'(vt[i].sum));
      check($sformatf("vec%0d_cout", i), 64'(bus.cout), 64'(vt[i].cout));
`ifdef CLA_32BIT_OVF_EN
      check($sformatf("vec%0d_ovf", i), 64'(bus.ovf), 64'(exp_ovf(vt[i].a, vt[i].b, vt[i].sum)));
`endif
    end

    // Mid-cycle input change must not disturb the held result.
    drive(32'h0000A1B2, 32'h0000A112, 1'b0);
    @(posedge clk); #1;
    drive(32'hFFFFFFFF, 32'h00000001, 1'b0);
    #3;
    check("hold_sum", 64'(bus.sum), 64'h000142C4);
    check("hold_cout", 64'(bus.cout), 64'h0);
    @(posedge clk); #1;
    check("after_hold_sum", 64'(bus.sum), 64'h0);
    check("after_hold_cout", 64'(bus.cout), 64'h1);

    // Asynchronous reset between edges while the result is nonzero.
    drive(32'h0000F9A0, 32'h0000D7E8, 1'b1);
    @(posedge clk); #2;
    check("pre_async_sum", 64'(bus.sum), 64'h0001D189);
    rst_n = 1'b0;
    #1;
    check("async_sum", 64'(bus.sum), 64'h0);
    check("async_cout", 64'(bus.cout), 64'h0);
    @(negedge clk) rst_n = 1'b1;
    @(posedge clk); #1;
    check("first_capture_sum", 64'(bus.sum), 64'h0001D189);

    for (int i = 0; i < 10000; i++) begin
      drive($urandom, $urandom, 1'($urandom_range(1)));
      ref_sum = {1'b0, bus.a} + {1'b0, bus.b} + 33'(bus.cin);
      @(posedge clk); #1;
      check("random", 64'({bus.cout, bus.sum}), 64'(ref_sum));
`ifdef CLA_32BIT_OVF_EN
      check("random_ovf", 64'(bus.ovf), 64'(exp_ovf(bus.a, bus.b, ref_sum[31:0])));
`endif
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
